// File: rtl/cache_line_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_mem_if
// Brief    : Refill (rd/ret) and write-back (wr) bus between cache and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_line_mem_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface
`default_nettype wire

// File: rtl/cache_line_mem.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_mem
// Brief    : Line-granular backing store serving cache refills and write-backs
//            with configurable latency. Define CACHE_MEM_STALL_EN to inject
//            LFSR-driven bubbles into read bursts.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_mem #(
  parameter int LINE_AW    = 8,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  cache_line_mem_if.slave bus
);

  localparam int NUM_LINES = 2 ** LINE_AW;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_BUSY  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [LINE_AW-1:0]   idx_q, idx_d;
  logic [1:0]           beat_q, beat_d;
  logic [2:0]           left_q, left_d;
  logic [127:0]         snap_q, snap_d;
  logic                 ret_valid_q, ret_valid_d;
  logic                 ret_last_q, ret_last_d;
  logic [31:0]          ret_data_q, ret_data_d;

  logic [127:0]         mem_q [NUM_LINES];
  logic [127:0]         mem_line_d;
  logic [6:0]           wr_base;
  logic [LINE_AW-1:0]   rd_idx, wr_idx;
  logic                 wr_accept, rd_accept, rd_is_line, bubble;
  logic                 unused_addr_bits;

  // Reserved type codes fall through to line operations.
  function automatic logic is_line_op(input logic [2:0] t);
    return !(t == 3'b000 || t == 3'b001 || t == 3'b010);
  endfunction

  assign rd_idx     = bus.rd_addr[LINE_AW+3:4];
  assign wr_idx     = bus.wr_addr[LINE_AW+3:4];
  assign wr_base    = {bus.wr_addr[3:2], 5'd0};
  assign rd_is_line = is_line_op(bus.rd_type);

  assign bus.wr_rdy    = (state_q == ST_IDLE);
  assign bus.rd_rdy    = (state_q == ST_IDLE) && !bus.wr_req;
  assign wr_accept     = bus.wr_req && bus.wr_rdy;
  assign rd_accept     = bus.rd_req && bus.rd_rdy;
  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_last  = ret_last_q;
  assign bus.ret_data  = ret_data_q;

  assign unused_addr_bits = ^{bus.rd_addr[31:LINE_AW+4], bus.rd_addr[1:0],
                              bus.wr_addr[31:LINE_AW+4], bus.wr_addr[1:0]};

`ifdef CACHE_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign bubble = lfsr_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign bubble = 1'b0;
`endif

  always_comb begin
    mem_line_d = mem_q[wr_idx];
    if (is_line_op(bus.wr_type)) begin
      mem_line_d = bus.wr_data;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wr_wstrb[b]) mem_line_d[wr_base + 7'(8 * b) +: 8] = bus.wr_data[8 * b +: 8];
      end
    end
  end

  // Storage survives reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_idx] <= mem_line_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    left_d      = left_q;
    snap_d      = snap_q;
    ret_valid_d = 1'b0;
    ret_last_d  = 1'b0;
    ret_data_d  = ret_data_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_accept) begin
          state_d = (WR_LATENCY > 0) ? ST_WR_BUSY : ST_IDLE;
          cnt_d   = 4'(WR_LATENCY);
        end else if (rd_accept) begin
          idx_d  = rd_idx;
          left_d = rd_is_line ? 3'd4 : 3'd1;
          beat_d = rd_is_line ? 2'd0 : bus.rd_addr[3:2];
          if (RD_LATENCY > 0) begin
            state_d = ST_RD_WAIT;
            cnt_d   = 4'(RD_LATENCY);
          end else begin
            state_d = ST_RD_BURST;
            snap_d  = mem_q[rd_idx];
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RD_BURST;
          cnt_d   = 4'd0;
          snap_d  = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RD_BURST: begin
        // One extra cycle after the final beat keeps rd_rdy low while ret_last is shown.
        if (left_q == 3'd0) begin
          state_d = ST_IDLE;
        end else if (!bubble) begin
          ret_valid_d = 1'b1;
          ret_last_d  = (left_q == 3'd1);
          ret_data_d  = snap_q[{beat_q, 5'd0} +: 32];
          beat_d      = beat_q + 2'd1;
          left_d      = left_q - 3'd1;
        end
      end
      ST_WR_BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      beat_q      <= 2'd0;
      left_q      <= 3'd0;
      snap_q      <= 128'd0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      left_q      <= left_d;
      snap_q      <= snap_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_mem
// Brief    : Self-checking bench for cache_line_mem against a line-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_mem;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  logic [127:0] model_mem [256];
  logic [127:0] rnd_line;
  logic [31:0]  rnd_addr;
  logic [7:0]   hot_idx [4] = '{8'h23, 8'h01, 8'h7f, 8'hff};
  logic [2:0]   type_tbl [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
`ifdef CACHE_MEM_STALL_EN
  int stall_seen = 0;
`endif

  cache_line_mem_if bus ();

  cache_line_mem #(
    .LINE_AW   (8),
    .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic line_type(input logic [2:0] t);
    return !(t inside {3'b000, 3'b001, 3'b010});
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [2:0] typ,
                          input logic [3:0] strb, input logic [127:0] data);
    int n;
    logic [31:0] word;
    bus.wr_req = 1'b1; bus.wr_addr = addr; bus.wr_type = typ;
    bus.wr_wstrb = strb; bus.wr_data = data;
    n = 0;
    while (!bus.wr_rdy && n < 50) begin @(posedge clk); #1; n++; end
    chk("wr_rdy_wait", bus.wr_rdy, 1'b1);
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    if (line_type(typ)) begin
      model_mem[addr[11:4]] = data;
    end else begin
      word = model_mem[addr[11:4]][addr[3:2]*32 +: 32];
      for (int b = 0; b < 4; b++) if (strb[b]) word[b*8 +: 8] = data[b*8 +: 8];
      model_mem[addr[11:4]][addr[3:2]*32 +: 32] = word;
    end
    n = 0;
    while (!bus.wr_rdy && n < 50) begin n++; @(posedge clk); #1; end
    chk("wr_busy_cycles", n, WR_LAT);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] typ, input string tag);
    int n, beats, first, nexp;
    logic        is_line;
    logic [1:0]  w;
    logic [127:0] line;
    logic [31:0] last_data;
    is_line = line_type(typ);
    nexp = is_line ? 4 : 1;
    line = model_mem[addr[11:4]];
    bus.rd_req = 1'b1; bus.rd_addr = addr; bus.rd_type = typ;
    n = 0;
    while (!bus.rd_rdy && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_rdy"}, bus.rd_rdy, 1'b1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    n = 0; beats = 0; first = -1; last_data = 32'd0;
    while (beats < nexp && n < 100) begin
      @(posedge clk); #1; n++;
      if (bus.ret_valid) begin
        if (beats == 0) first = n;
        w = is_line ? beats[1:0] : addr[3:2];
        chk({tag, "_data"}, bus.ret_data, line[w*32 +: 32]);
        chk({tag, "_last"}, bus.ret_last, (beats == nexp - 1));
        last_data = bus.ret_data;
        beats++;
      end
    end
    chk({tag, "_beats"}, beats, nexp);
`ifdef CACHE_MEM_STALL_EN
    if (first != 1 + RD_LAT || n - first != nexp - 1) stall_seen = 1;
`else
    chk({tag, "_latency"}, first, 1 + RD_LAT);
`endif
    chk({tag, "_rdy_on_last"}, bus.rd_rdy, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_rdy_after"}, bus.rd_rdy, 1'b1);
    chk({tag, "_valid_after"}, bus.ret_valid, 1'b0);
    chk({tag, "_data_hold"}, bus.ret_data, last_data);
  endtask

  initial begin
    int beats, n, k;
    bus.rd_req = 0; bus.rd_type = 0; bus.rd_addr = 0;
    bus.wr_req = 0; bus.wr_type = 0; bus.wr_addr = 0; bus.wr_wstrb = 0; bus.wr_data = 0;

    // Reset state, including the combinational rd_rdy dependence on wr_req.
    #1;
    chk("rst_ret_valid", bus.ret_valid, 1'b0);
    chk("rst_ret_last", bus.ret_last, 1'b0);
    chk("rst_ret_data", bus.ret_data, 32'd0);
    chk("rst_wr_rdy", bus.wr_rdy, 1'b1);
    chk("rst_rd_rdy", bus.rd_rdy, 1'b1);
    bus.wr_req = 1'b1; #1;
    chk("rst_rd_rdy_wrreq", bus.rd_rdy, 1'b0);
    bus.wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Line write then line read.
    do_write(32'h0000_1230, 3'b100, 4'h0, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    do_read(32'h0000_1230, 3'b100, "line_rd");

    // Partial word write then single read.
    do_write(32'h0000_1238, 3'b010, 4'b0011, {96'd0, 32'hAAAA_BBBB});
    chk("model_word", model_mem[8'h23][95:64], 32'h3333_BBBB);
    do_read(32'h0000_1238, 3'b010, "word_rd");

    // Simultaneous read and write to the same line: write must win.
    rnd_line = {$urandom, $urandom, $urandom, $urandom};
    bus.wr_req = 1'b1; bus.wr_addr = 32'h0000_1234; bus.wr_type = 3'b100;
    bus.wr_wstrb = 4'h0; bus.wr_data = rnd_line;
    bus.rd_req = 1'b1; bus.rd_addr = 32'h0000_1230; bus.rd_type = 3'b100;
    #1;
    chk("both_rd_rdy", bus.rd_rdy, 1'b0);
    chk("both_wr_rdy", bus.wr_rdy, 1'b1);
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    model_mem[8'h23] = rnd_line;
    do_read(32'h0000_1230, 3'b100, "both_rd");

    // Reset during the second beat of a line burst.
    bus.rd_req = 1'b1; bus.rd_addr = 32'h0000_1230; bus.rd_type = 3'b100;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    beats = 0; n = 0;
    while (beats < 2 && n < 100) begin
      @(posedge clk); #1; n++;
      if (bus.ret_valid) beats++;
    end
    chk("midrst_beats_seen", beats, 2);
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", bus.ret_valid, 1'b0);
    chk("midrst_last", bus.ret_last, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_rd_rdy", bus.rd_rdy, 1'b1);
    do_read(32'h0000_1230, 3'b100, "midrst_reread");

    // Upper address bits alias onto the same line.
    rnd_line = {$urandom, $urandom, $urandom, $urandom};
    do_write(32'h0000_0010, 3'b100, 4'h0, rnd_line);
    do_read(32'hFFFF_F010, 3'b100, "alias_rd");
    chk("alias_model", model_mem[8'h01], rnd_line);

    // Random mixed traffic over a few hot lines, all preloaded first.
    for (int i = 0; i < 4; i++)
      do_write({20'h0, hot_idx[i], 4'h0}, 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 60; i++) begin
      rnd_addr = {$urandom_range(0, 32'hF_FFFF), hot_idx[$urandom_range(0, 3)], 2'($urandom), 2'($urandom)};
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        do_write(rnd_addr, type_tbl[k], 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      else
        do_read(rnd_addr, type_tbl[k], "rand_rd");
    end

`ifdef CACHE_MEM_STALL_EN
    for (int i = 0; i < 100; i++) begin
      rnd_addr = {20'h0, hot_idx[$urandom_range(0, 3)], 4'($urandom)};
      do_read(rnd_addr, 3'b100, "stall_rd");
    end
    chk("stall_seen", stall_seen, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_line_mem.md
# cache_line_mem

Line-granular backing memory that sits directly downstream of the `cache` block and serves its refill (`rd_*`/`ret_*`) and write-back (`wr_*`) interfaces. It replaces the hard-wired responder used during cache bring-up with a real storage array, so replaced dirty lines can be read back by later refills. It has configurable read and write latency and an optional bubble-injection mode that stresses the cache refill logic. Requests are served one at a time.

## Interface
- `LINE_AW`, 8: line-index width; the array holds 2^LINE_AW lines of 128 bits.
- `RD_LATENCY`, 2: idle cycles between read acceptance and the first `ret_valid`; range 0..15.
- `WR_LATENCY`, 1: cycles `wr_rdy` stays low after a write is accepted; range 0..15.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rd_req` in 1: read request.
- `rd_type` in 3: 3'b100 = line (4 beats); 3'b000/001/010 = byte/half/word (1 beat).
- `rd_addr` in 32: byte address.
- `rd_rdy` out 1: read can be accepted this cycle.
- `ret_valid` out 1: `ret_data` is valid this cycle.
- `ret_last` out 1: final beat of the current read.
- `ret_data` out 32: returned word.
- `wr_req` in 1: write request.
- `wr_type` in 3: 3'b100 = full line; 3'b000/001/010 = single word under `wr_wstrb`.
- `wr_addr` in 32: byte address.
- `wr_wstrb` in 4: byte enables; used only for non-line writes.
- `wr_data` in 128: line data; non-line writes use `wr_data[31:0]`.
- `wr_rdy` out 1: write can be accepted this cycle.

## Operation
- Line index is `addr[LINE_AW+3:4]`. Upper address bits are ignored, so aliasing is allowed. Word select is `addr[3:2]`.
- States:
  - IDLE.
  - RD_WAIT: latency countdown.
  - RD_BURST: returning beats.
  - WR_BUSY: write latency countdown.
- `wr_rdy` = (state == IDLE). `rd_rdy` = (state == IDLE) && !`wr_req`. When both requests are present, the write wins; a write-back therefore always lands before a refill of the same line.
- Write acceptance (`wr_req && wr_rdy`):
  - The array updates on that edge.
  - Line write: all 128 bits are written.
  - Word write: bytes of word `addr[3:2]` are written where `wr_wstrb` is 1.
  - Next state is WR_BUSY if `WR_LATENCY` > 0, otherwise IDLE.
- Read acceptance (`rd_req && rd_rdy`):
  - Latch the index, word select and beat count: 4 for a line read, else 1.
  - Next state is RD_WAIT if `RD_LATENCY` > 0, else RD_BURST.
- RD_BURST:
  - The line is snapshotted on entry.
  - Line reads return words 0,1,2,3 in order, regardless of `addr[3:2]`.
  - Single reads return the addressed word.
  - `ret_last` is asserted with the final beat; the state then returns to IDLE.
- No backpressure on `ret_*`: the cache must accept every beat.
- Array contents are not cleared by reset; they are undefined until written. The bench preloads the array by hierarchical access or by writes.
- Reset mid-operation aborts the operation. `ret_valid` drops immediately, the state goes to IDLE, and array contents are retained. A write accepted on the edge before reset is retained.
- Requests with reserved `rd_type`/`wr_type` codes (011, 101-111) are treated as line operations.

## Timing
- Reset values:
  - `ret_valid` = 0, `ret_last` = 0, `ret_data` = 0.
  - `rd_rdy` = !`wr_req`, `wr_rdy` = 1.
  - Internal counters are 0 and the state is IDLE.
- `ret_valid`, `ret_last` and `ret_data` are registered. `rd_rdy` and `wr_rdy` are combinational from the state and `wr_req`.
- Read accepted at edge T: first beat is visible in the cycle after edge T+1+`RD_LATENCY`. Without stalls, a line burst occupies 4 consecutive cycles.
- `rd_rdy` returns high in the cycle after the last beat. Back-to-back reads are therefore separated by at least one idle cycle.
- Write accepted at edge T:
  - `wr_rdy` is low for `WR_LATENCY` cycles after T.
  - A read of the same line accepted afterwards returns the new data.
- `ret_data` holds its last value when `ret_valid` = 0.

## Configuration
- `CACHE_MEM_STALL_EN` defined:
  - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle while the block is out of reset.
  - In RD_BURST, any cycle with `lfsr[0]` = 1 is a bubble: `ret_valid` = 0 and the beat is held.
  - The first beat is also subject to bubbles. Beat order and data are unchanged.
- `CACHE_MEM_STALL_EN` undefined: no LFSR is present and beats are strictly back-to-back.

## Test plan
- Reset, then line write to addr 0x0000_1230 with data 128'h4444_4444_3333_3333_2222_2222_1111_1111, then line read of the same address with `RD_LATENCY` = 2 → `ret_valid` first high 3 cycles after acceptance; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444; `ret_last` only on beat 4.
- Word write, `wr_type` = 010, addr 0x0000_1238, `wr_wstrb` = 4'b0011, `wr_data[31:0]` = 0xAAAA_BBBB over the line above, then word read of 0x0000_1238 → one beat 0x3333_BBBB with `ret_last` = 1.
- `rd_req` and `wr_req` asserted in the same IDLE cycle to the same line → write accepted first; `rd_rdy` low during that cycle; the subsequent read returns the newly written data.
- `reset` asserted during beat 2 of a line burst → `ret_valid` low in the same cycle; after release, `rd_rdy` = 1 and a re-read returns the unchanged line.
- Alias check with `LINE_AW` = 8: write addr 0x0000_0010, then read 0xFFFF_F010 → identical line returned.
- With `CACHE_MEM_STALL_EN`: 100 random line reads → each burst has exactly 4 `ret_valid` beats in order, `ret_last` on the 4th, and at least one burst contains a bubble.
